// File: rtl/aes_byte_streamer.sv
// Byte-stream front end for the combinational cipher core: collects key and
// plaintext bytes, waits a settle window, then streams the 16 result bytes out.
module aes_byte_streamer #(
  parameter int Nk          = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             rekey,
  output logic [Nk*32-1:0] cipher_key,
  output logic [127:0]     cipher_data,
  input  logic [127:0]     cipher_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             busy
);

  localparam int KW = Nk * 32;
  localparam int KB = 4 * Nk;

  typedef enum logic [1:0] {
    S_LOAD_KEY,
    S_LOAD_DATA,
    S_WAIT,
    S_SEND
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            rekey_pend_q, rekey_pend_d;
  logic [KW-1:0]   key_q, key_d;
  logic [127:0]    data_q, data_d;
  logic [127:0]    sr_q, sr_d;
  logic [7:0]      wcnt_q, wcnt_d;
  logic            in_xfer, out_xfer;

  assign in_ready    = (state_q == S_LOAD_KEY) || (state_q == S_LOAD_DATA);
  assign out_valid   = (state_q == S_SEND);
  assign busy        = (state_q == S_WAIT) || (state_q == S_SEND);
  assign out_byte    = sr_q[127:120];
  assign cipher_key  = key_q;
  assign cipher_data = data_q;
  assign in_xfer     = in_valid && in_ready;
  assign out_xfer    = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rekey_pend_d = rekey_pend_q | rekey;
    key_d        = key_q;
    data_d       = data_q;
    sr_d         = sr_q;
    wcnt_d       = wcnt_q;
    case (state_q)
      S_LOAD_KEY: begin
        rekey_pend_d = 1'b0;
        if (in_xfer) begin
          key_d = {key_q[KW-9:0], in_byte};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(KB - 1)) begin
            state_d = S_LOAD_DATA;
            cnt_d   = '0;
          end
        end
      end
      S_LOAD_DATA: begin
        // A byte arriving alongside a pending rekey wins; the rekey waits for block end.
        if (in_xfer) begin
          data_d = {data_q[119:0], in_byte};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            state_d = S_WAIT;
            cnt_d   = '0;
            wcnt_d  = 8'(WAIT_CYCLES);
          end
        end else if (rekey_pend_q && (cnt_q == '0)) begin
          state_d      = S_LOAD_KEY;
          rekey_pend_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (wcnt_q <= 8'd1) begin
          sr_d    = cipher_result;
          state_d = S_SEND;
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end
      S_SEND: begin
        if (out_xfer) begin
          sr_d  = {sr_q[119:0], 8'h00};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            cnt_d = '0;
            if (rekey_pend_q) begin
              state_d      = S_LOAD_KEY;
              rekey_pend_d = 1'b0;
            end else begin
              state_d = S_LOAD_DATA;
            end
          end
        end
      end
      default: state_d = S_LOAD_KEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD_KEY;
      cnt_q        <= '0;
      rekey_pend_q <= 1'b0;
      key_q        <= '0;
      data_q       <= '0;
      sr_q         <= '0;
      wcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rekey_pend_q <= rekey_pend_d;
      key_q        <= key_d;
      data_q       <= data_d;
      sr_q         <= sr_d;
      wcnt_q       <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_aes_byte_streamer.sv
// Directed bench for aes_byte_streamer; the cipher core is stood in for by a
// lookup of known FIPS-197 vectors with a simple fallback mix for other inputs.
module tb_aes_byte_streamer;

  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT3  = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  function automatic logic [127:0] model128(input logic [127:0] k, input logic [127:0] d);
    if (k == K1 && d == PT1) return CT1;
    if (k == K2 && d == PT2) return CT2;
    return d ^ k ^ {16{8'h5a}};
  endfunction

  function automatic logic [127:0] model256(input logic [255:0] k, input logic [127:0] d);
    if (k == K256 && d == PT1) return CT256;
    return d ^ k[127:0] ^ k[255:128];
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         a_in_valid, a_in_ready, a_rekey, a_out_valid, a_out_ready, a_busy;
  logic [7:0]   a_in_byte, a_out_byte;
  logic [127:0] a_key, a_data, a_result;

  logic         b_in_valid, b_in_ready, b_rekey, b_out_valid, b_out_ready, b_busy;
  logic [7:0]   b_in_byte, b_out_byte;
  logic [255:0] b_key;
  logic [127:0] b_data, b_result;

  assign a_result = model128(a_key, a_data);
  assign b_result = model256(b_key, b_data);

  aes_byte_streamer #(.Nk(4), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_byte(a_in_byte), .rekey(a_rekey), .cipher_key(a_key), .cipher_data(a_data),
    .cipher_result(a_result), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_byte(a_out_byte), .busy(a_busy)
  );

  aes_byte_streamer #(.Nk(8), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_byte(b_in_byte), .rekey(b_rekey), .cipher_key(b_key), .cipher_data(b_data),
    .cipher_result(b_result), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_byte(b_out_byte), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic a_push(input logic [7:0] b, output bit to);
    int g;
    g = 0;
    to = 1'b0;
    a_in_valid = 1'b1;
    a_in_byte  = b;
    while (!a_in_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!a_in_ready) to = 1'b1;
    else begin
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
  endtask

  task automatic a_load(input logic [127:0] v, input bit gaps, output bit to);
    bit t;
    to = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      a_push(v[127-8*i -: 8], t);
      to |= t;
    end
  endtask

  task automatic a_pop(input bit bp, input bit rk, output logic [127:0] got,
                       output int unstable, output int rdy_hi, output bit to);
    int g;
    logic [7:0] h;
    got = '0; unstable = 0; rdy_hi = 0; to = 1'b0;
    for (int i = 0; i < 16; i++) begin
      g = 0;
      while (!a_out_valid && g < 100) begin
        if (a_in_ready) rdy_hi++;
        @(posedge clk); #1;
        g++;
      end
      if (!a_out_valid) begin
        to = 1'b1;
        break;
      end
      if (bp) begin
        h = a_out_byte;
        a_out_ready = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
          if (a_out_byte !== h || a_out_valid !== 1'b1) unstable++;
          if (a_in_ready) rdy_hi++;
        end
      end
      a_out_ready = 1'b1;
      a_rekey = rk && (i == 5);
      if (a_in_ready) rdy_hi++;
      got = {got[119:0], a_out_byte};
      @(posedge clk); #1;
      a_rekey = 1'b0;
    end
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", a_out_valid); end
    checks++; if (a_out_byte !== 8'h00) begin errors++; $display("FAIL reset_out_byte got %h want 00", a_out_byte); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", a_busy); end
    checks++; if (a_key !== '0) begin errors++; $display("FAIL reset_key got %h want 0", a_key); end
    checks++; if (a_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", a_data); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips128;
    bit t1, t2, t3;
    logic [127:0] got;
    int us, rh;
    a_load(K1, 1'b0, t1);
    checks++; if (a_key !== K1) begin errors++; $display("FAIL fips_key got %h want %h", a_key, K1); end
    a_load(PT1, 1'b0, t2);
    checks++; if (a_data !== PT1) begin errors++; $display("FAIL fips_data got %h want %h", a_data, PT1); end
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b1 || a_in_ready !== 1'b0)
      begin errors++; $display("FAIL fips_wait got v=%0b b=%0b r=%0b want 0 1 0", a_out_valid, a_busy, a_in_ready); end
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL fips_latency got out_valid=%0b want 1", a_out_valid); end
    a_pop(1'b0, 1'b0, got, us, rh, t3);
    checks++; if (got !== CT1) begin errors++; $display("FAIL fips_ct got %h want %h", got, CT1); end
    checks++; if ((t1 | t2 | t3) !== 1'b0) begin errors++; $display("FAIL fips_timeout got 1 want 0"); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fips_ready_after got %0b want 1", a_in_ready); end
  endtask

  task automatic test_key_reuse;
    bit t1, t2, t3, t4;
    logic [127:0] got;
    int us, rh;
    a_load(PT1, 1'b1, t1);
    a_pop(1'b1, 1'b0, got, us, rh, t2);
    checks++; if (got !== CT1) begin errors++; $display("FAIL reuse_ct1 got %h want %h", got, CT1); end
    checks++; if (us !== 0) begin errors++; $display("FAIL reuse_hold1 got %0d unstable want 0", us); end
    checks++; if (rh !== 0) begin errors++; $display("FAIL reuse_ready1 got %0d high cycles want 0", rh); end
    a_load(PT3, 1'b1, t3);
    a_pop(1'b1, 1'b0, got, us, rh, t4);
    checks++; if (got !== model128(K1, PT3)) begin errors++; $display("FAIL reuse_ct2 got %h want %h", got, model128(K1, PT3)); end
    checks++; if (us !== 0 || rh !== 0) begin errors++; $display("FAIL reuse_hs2 got us=%0d rh=%0d want 0 0", us, rh); end
    checks++; if (a_key !== K1 || (t1 | t2 | t3 | t4) !== 1'b0) begin errors++; $display("FAIL reuse_key got %h want %h", a_key, K1); end
  endtask

  task automatic test_rekey_send;
    bit t1, t2, t3, t4, t5;
    logic [127:0] got;
    int us, rh;
    a_load(PT1, 1'b0, t1);
    a_pop(1'b0, 1'b1, got, us, rh, t2);
    checks++; if (got !== CT1) begin errors++; $display("FAIL rksend_ct1 got %h want %h", got, CT1); end
    a_load(K2, 1'b0, t3);
    checks++; if (a_key !== K2) begin errors++; $display("FAIL rksend_key got %h want %h", a_key, K2); end
    a_load(PT2, 1'b0, t4);
    a_pop(1'b0, 1'b0, got, us, rh, t5);
    checks++; if (got !== CT2 || (t1 | t2 | t3 | t4 | t5) !== 1'b0) begin errors++; $display("FAIL rksend_ct2 got %h want %h", got, CT2); end
  endtask

  task automatic test_rekey_idle;
    bit t1, t2, t3, t4, t5, t6, t7, t8, t9;
    logic [127:0] got;
    int us, rh;
    a_rekey = 1'b1;
    @(posedge clk); #1;
    a_rekey = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    a_load(K1, 1'b0, t1);
    checks++; if (a_key !== K1) begin errors++; $display("FAIL rkidle_key got %h want %h", a_key, K1); end
    a_load(PT1, 1'b0, t2);
    a_pop(1'b0, 1'b0, got, us, rh, t3);
    checks++; if (got !== CT1) begin errors++; $display("FAIL rkidle_ct got %h want %h", got, CT1); end
    a_rekey = 1'b1;
    a_push(PT3[127:120], t4);
    a_rekey = 1'b0;
    for (int i = 1; i < 16; i++) begin
      a_push(PT3[127-8*i -: 8], t5);
      t4 |= t5;
    end
    checks++; if (a_data !== PT3 || a_key !== K1) begin errors++; $display("FAIL rkcoin_data got %h want %h", a_data, PT3); end
    a_pop(1'b0, 1'b0, got, us, rh, t6);
    checks++; if (got !== model128(K1, PT3)) begin errors++; $display("FAIL rkcoin_ct got %h want %h", got, model128(K1, PT3)); end
    a_load(K2, 1'b0, t7);
    a_load(PT2, 1'b0, t8);
    a_pop(1'b0, 1'b0, got, us, rh, t9);
    checks++; if (got !== CT2 || a_key !== K2) begin errors++; $display("FAIL rkcoin_deferred got %h want %h", got, CT2); end
    checks++; if ((t1 | t2 | t3 | t4 | t6 | t7 | t8 | t9) !== 1'b0) begin errors++; $display("FAIL rkidle_timeout got 1 want 0"); end
  endtask

  task automatic test_async_reset;
    bit t, t1, t2, t3, t4, t5;
    logic [127:0] got;
    int us, rh, g;
    for (int i = 0; i < 7; i++) a_push(PT1[127-8*i -: 8], t);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_key !== '0 || a_data !== '0 || a_in_ready !== 1'b1 || a_busy !== 1'b0)
      begin errors++; $display("FAIL arst_load got key=%h data=%h r=%0b b=%0b want 0 0 1 0", a_key, a_data, a_in_ready, a_busy); end
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    a_load(K1, 1'b0, t1);
    a_load(PT1, 1'b0, t2);
    g = 0;
    while (!a_out_valid && g < 50) begin @(posedge clk); #1; g++; end
    a_out_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    a_out_ready = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_out_byte !== CT1[127-8*5 -: 8])
      begin errors++; $display("FAIL arst_presend got v=%0b byte=%h want 1 %h", a_out_valid, a_out_byte, CT1[127-8*5 -: 8]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_out_byte !== 8'h00 || a_busy !== 1'b0 || a_in_ready !== 1'b1 || a_key !== '0)
      begin errors++; $display("FAIL arst_send got v=%0b byte=%h b=%0b r=%0b want 0 00 0 1", a_out_valid, a_out_byte, a_busy, a_in_ready); end
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    a_load(K2, 1'b0, t3);
    a_load(PT2, 1'b0, t4);
    a_pop(1'b0, 1'b0, got, us, rh, t5);
    checks++; if (got !== CT2 || (t1 | t2 | t3 | t4 | t5) !== 1'b0) begin errors++; $display("FAIL arst_after got %h want %h", got, CT2); end
  endtask

  task automatic test_aes256;
    logic [127:0] got;
    int to, busy_n, wait_n;
    to = 0; busy_n = 0; wait_n = 0; got = '0;
    for (int i = 0; i < 48; i++) begin
      b_in_valid = 1'b1;
      b_in_byte  = (i < 32) ? K256[255-8*i -: 8] : PT1[127-8*(i-32) -: 8];
      if (!b_in_ready) to++;
      @(posedge clk); #1;
    end
    b_in_valid  = 1'b0;
    checks++; if (b_key !== K256 || b_data !== PT1) begin errors++; $display("FAIL aes256_load got key=%h want %h", b_key, K256); end
    b_out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (!b_busy) break;
      busy_n++;
      if (b_out_valid) got = {got[119:0], b_out_byte};
      else wait_n++;
      @(posedge clk); #1;
    end
    b_out_ready = 1'b0;
    checks++; if (got !== CT256) begin errors++; $display("FAIL aes256_ct got %h want %h", got, CT256); end
    checks++; if (busy_n !== 19 || wait_n !== 3) begin errors++; $display("FAIL aes256_busy got busy=%0d wait=%0d want 19 3", busy_n, wait_n); end
    checks++; if (to !== 0) begin errors++; $display("FAIL aes256_ready got %0d stalls want 0", to); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_byte = '0; a_rekey = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_byte = '0; b_rekey = 1'b0; b_out_ready = 1'b0;
    #1;
    test_reset();
    test_fips128();
    test_key_reuse();
    test_rekey_send();
    test_rekey_idle();
    test_async_reset();
    test_aes256();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
